// File: rtl/data_mem_lsu_if.sv
// Purpose : request/response bundle between the MEM stage and the data memory LSU.
// Latency : n/a (signal bundle only).
// Backpressure: req_ready from the memory side; responses cannot be stalled.
// Ports   : req_valid/req_ready handshake, req_we/req_size/req_unsigned/req_addr/req_wdata,
//           rsp_valid/rsp_rdata/rsp_err. master = pipeline side, slave = memory side.
interface data_mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Purpose : byte-addressed data memory + load/store unit (LB/LBU/LH/LHU/LW, SB/SH/SW),
//           self-clearing after reset through an init sequencer.
// Latency : one cycle from accept to registered response; stores visible to the next request.
// Backpressure: req_ready low for DEPTH cycles of memory clear after reset, then always high.
// Ports   : clk, RST (sync, active-high), bus (data_mem_lsu_if.slave),
//           init_busy (clear in progress), Test_value (word 0 low half, combinational).
module data_mem_lsu #(
  parameter int          DEPTH      = 256,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              RST,
  data_mem_lsu_if.slave     bus,
  output logic              init_busy,
  output logic [15:0]       Test_value
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   init_ptr;
  logic [31:0]     mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    init_busy     = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (init_ptr == IW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        bus.req_ready = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  // A request on the reset edge is dropped: reset wins over everything.
  logic accept;
  assign accept = bus.req_valid & bus.req_ready & ~RST;

  // ------------------------------------------------------------- decode
  // The extra top bit of the subtraction is the borrow, i.e. req_addr < BASE_ADDR.
  logic [ADDR_WIDTH:0]   off_ext;
  logic [ADDR_WIDTH-1:0] off;
  logic                  below_base;
  logic [1:0]            lane;
  logic [IW-1:0]         widx;
  logic                  range_err;
  logic                  size_err;
  logic                  err;

  assign off_ext    = {1'b0, bus.req_addr} - {1'b0, ADDR_WIDTH'(BASE_ADDR)};
  assign off        = off_ext[ADDR_WIDTH-1:0];
  assign below_base = off_ext[ADDR_WIDTH];
  assign lane       = off[1:0];
  assign widx       = off[IW+1:2];
  assign range_err  = (off >> 2) >= ADDR_WIDTH'(DEPTH);

  always_comb begin
    size_err = 1'b0;
    case (bus.req_size)
      2'b00:   size_err = 1'b0;
      2'b01:   size_err = lane[0];
      2'b10:   size_err = (lane != 2'b00);
      default: size_err = 1'b1;
    endcase
  end

  assign err = size_err | below_base | range_err;

  // --------------------------------------------------------------- load
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign rd_word = mem[widx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = rd_word;
    case (bus.req_size)
      2'b00:   ld_data = bus.req_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = bus.req_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // -------------------------------------------------------------- store
  // Data is replicated across lanes so the byte enables alone pick the target lanes.
  logic [3:0]  be;
  logic [31:0] wd;

  always_comb begin
    be = 4'b0000;
    wd = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = bus.req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      if (state == INIT) begin
        mem[init_ptr] <= '0;
      end else if (accept && bus.req_we && !err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][i*8 +: 8] <= wd[i*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------- response
  // rdata/err only update on an accept so they hold between responses.
  always_ff @(posedge clk) begin
    if (RST) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_err   <= err;
        bus.rsp_rdata <= (err || bus.req_we) ? 32'h0 : ld_data;
      end
    end
  end

  assign Test_value = mem[0][15:0];

endmodule
